wishbone_lsu_master: RTL and testbench

- Core-side load/store unit that converts one CPU memory request into a single Wishbone classic read or write cycle.
- Sits directly upstream of the Wishbone slaves (instruction/data ROM slave, RAM slave).
- Generates the byte-lane select, replicates store data onto the lanes, extracts and sign/zero-extends load data, and flags misaligned accesses.
- The core stalls on o_BUSY until o_DONE or o_ERR.

---
 rtl/pygmy_lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/wishbone_lsu_master.sv | 173 +++++++++++++++++
 tb/tb_wishbone_lsu_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pygmy_lsu_pkg.sv
// Shared types and helpers for the Wishbone load/store unit.
// The optional bus timeout is enabled with the LSU_TIMEOUT_EN macro (see wishbone_lsu_master).
package pygmy_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

  // Size code 2'b11 has no legal encoding, so it is reported like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: select generation, store replication,
// and load extraction with sign/zero extension.
module lsu_lane_align
  import pygmy_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_pick;
  logic [15:0] half_pick;

  assign byte_pick = rdata_raw[{addr_lo, 3'b000} +: 8];
  assign half_pick = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    sel        = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata_raw;
    case (size)
      SZ_BYTE: begin
        sel        = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~unsigned_ld & byte_pick[7]}}, byte_pick};
      end
      SZ_HALF: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~unsigned_ld & half_pick[15]}}, half_pick};
      end
      SZ_WORD: begin
        sel = 4'b1111;
      end
      default: begin
        sel = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/wishbone_lsu_master.sv
// Turns one core load/store request into a single Wishbone classic cycle.
// Define LSU_TIMEOUT_EN to abort a BUS phase that never sees ACK.
module wishbone_lsu_master
  import pygmy_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_REQ,
  input  logic                  i_WE,
  input  logic [1:0]            i_SIZE,
  input  logic                  i_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_WDATA,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERR,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic [ADDR_WIDTH-1:0] o_ADDR,
  output logic [DATA_WIDTH-1:0] o_DATA,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  output logic [3:0]            o_SEL,
  output logic                  o_WE,
  output logic                  o_STB,
  output logic                  o_CYC,
  input  logic                  i_ACK
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]            wb_sel_q, wb_sel_d;
  logic                  wb_we_q, wb_we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]            tmo_q, tmo_d;
`endif

  logic [1:0]  al_size;
  logic [1:0]  al_lo;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  assign al_size = (state_q == IDLE) ? i_SIZE : size_q;
  assign al_lo   = (state_q == IDLE) ? i_ADDR[1:0] : addr_lo_q;

  lsu_lane_align u_align (
    .size        (al_size),
    .addr_lo     (al_lo),
    .unsigned_ld (uns_q),
    .wdata       (i_WDATA),
    .rdata_raw   (i_DATA),
    .sel         (al_sel),
    .wdata_lane  (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_lo_d = addr_lo_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_sel_d  = wb_sel_q;
    wb_we_d   = wb_we_q;
    rdata_d   = rdata_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_REQ) begin
          we_d      = i_WE;
          size_d    = i_SIZE;
          uns_d     = i_UNSIGNED;
          addr_lo_d = i_ADDR[1:0];
          if (is_misaligned(i_SIZE, i_ADDR[1:0])) begin
            state_d = ERR;
          end else begin
            state_d   = BUS;
            wb_addr_d = {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
            wb_data_d = al_wdata;
            wb_sel_d  = al_sel;
            wb_we_d   = i_WE;
`ifdef LSU_TIMEOUT_EN
            tmo_d     = 8'd0;
`endif
          end
        end
      end
      BUS: begin
        // Bus-facing registers return to zero whenever the cycle ends.
        if (i_ACK) begin
          state_d   = RESP;
          if (!we_q) rdata_d = al_rdata;
          wb_addr_d = '0;
          wb_data_d = '0;
          wb_sel_d  = '0;
          wb_we_d   = 1'b0;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ERR;
          wb_addr_d = '0;
          wb_data_d = '0;
          wb_sel_d  = '0;
          wb_we_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_sel_q  <= '0;
      wb_we_q   <= 1'b0;
      rdata_q   <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_lo_q <= addr_lo_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_sel_q  <= wb_sel_d;
      wb_we_q   <= wb_we_d;
      rdata_q   <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign o_BUSY  = (state_q != IDLE);
  assign o_DONE  = (state_q == RESP);
  assign o_ERR   = (state_q == ERR);
  assign o_CYC   = (state_q == BUS);
  assign o_STB   = (state_q == BUS);
  assign o_RDATA = rdata_q;
  assign o_ADDR  = wb_addr_q;
  assign o_DATA  = wb_data_q;
  assign o_SEL   = wb_sel_q;
  assign o_WE    = wb_we_q;

endmodule

// File: tb/tb_wishbone_lsu_master.sv
// Directed bench for wishbone_lsu_master with a wait-state slave model and a completion scoreboard.
module tb_wishbone_lsu_master;

  logic        clk = 1'b0;
  logic        rst, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, o_addr, o_data, i_data;
  logic        busy, done, err, o_we, stb, cyc, ack;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  wishbone_lsu_master dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_WE(we), .i_SIZE(size),
    .i_UNSIGNED(uns), .i_ADDR(addr), .i_WDATA(wdata),
    .o_BUSY(busy), .o_DONE(done), .o_ERR(err), .o_RDATA(rdata),
    .o_ADDR(o_addr), .o_DATA(o_data), .i_DATA(i_data), .o_SEL(sel),
    .o_WE(o_we), .o_STB(stb), .o_CYC(cyc), .i_ACK(ack)
  );

  // Slave: ACKs combinationally once STB has been high for sl_wait cycles.
  logic [7:0]  sl_cnt = 8'd0;
  logic [7:0]  sl_wait = 8'd1;
  logic [31:0] sl_data = 32'h0;
  logic        force_ack = 1'b0;
  always @(posedge clk) sl_cnt <= stb ? sl_cnt + 8'd1 : 8'd0;
  assign ack    = (stb && (sl_cnt == sl_wait)) || force_ack;
  assign i_data = sl_data;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
    logic        chk_rd;
    int          cyc_at;
    int          bus_cycles;
  } exp_t;
  exp_t q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int bus_cnt  = 0;
  logic [3:0]  exp_sel;
  logic [31:0] exp_oaddr, exp_odata;
  logic        exp_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the bus and any completion, 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_no++;
    if (cyc) begin
      bus_cnt++;
      chk("stb", {31'b0, stb}, 32'd1);
      chk("sel", {28'b0, sel}, {28'b0, exp_sel});
      chk("adr", o_addr, exp_oaddr);
      chk("we", {31'b0, o_we}, {31'b0, exp_we});
      if (exp_we) chk("wdat", o_data, exp_odata);
    end
    if (done || err) begin
      chk("pending", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("err_flag", {31'b0, err}, {31'b0, e.is_err});
        chk("resp_cycle", 32'(cyc_no), 32'(e.cyc_at));
        chk("cyc_len", 32'(bus_cnt), 32'(e.bus_cycles));
        if (e.chk_rd) chk("rdata", rdata, e.rdata);
        $display("txn done=%0b err=%0b rdata=%h cycle=%0d", done, err, rdata, cyc_no);
      end
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] sdat, input logic [7:0] swait,
                       input logic e_err, input logic [3:0] e_sel, input logic [31:0] e_oaddr,
                       input logic [31:0] e_odata, input logic [31:0] e_rdata,
                       input logic e_chk_rd, input int e_bus, input int e_lat);
    exp_t e;
    e.is_err = e_err; e.rdata = e_rdata; e.chk_rd = e_chk_rd;
    e.cyc_at = cyc_no + e_lat; e.bus_cycles = e_bus;
    q.push_back(e);
    exp_sel = e_sel; exp_oaddr = e_oaddr; exp_odata = e_odata; exp_we = w;
    sl_data = sdat; sl_wait = swait; bus_cnt = 0;
    we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    tick();
    chk("idle_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    exp_sel = '0; exp_oaddr = '0; exp_odata = '0; exp_we = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'd0);
    chk("rst_adr", o_addr, 32'd0);
    chk("rst_dat", o_data, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();

    // word load, 1 wait: CYC cycles 1-2, DONE cycle 3
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 8'd1,
          1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 2, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80000000, 8'd1,
          1'b0, 4'b1000, 32'h10, 32'h0, 32'hFFFFFF80, 1'b1, 2, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80000000, 8'd0,
          1'b0, 4'b1000, 32'h10, 32'h0, 32'h00000080, 1'b1, 1, 2);
    // half store; load result must survive it
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 8'd2,
          1'b0, 4'b1100, 32'h20, 32'hABCDABCD, 32'h0, 1'b0, 3, 4);
    chk("rdata_hold", rdata, 32'h00000080);
    issue(1'b1, 2'b00, 1'b0, 32'h1001, 32'h1234565A, 32'h0, 8'd1,
          1'b0, 4'b0010, 32'h1000, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h87654321, 8'd1,
          1'b0, 4'b1100, 32'h40, 32'h0, 32'h00008765, 1'b1, 2, 3);
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h8765C321, 8'd3,
          1'b0, 4'b0011, 32'h40, 32'h0, 32'hFFFFC321, 1'b1, 4, 5);
    issue(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h0000_7F00, 8'd1,
          1'b0, 4'b0010, 32'h40, 32'h0, 32'h0000007F, 1'b1, 2, 3);
    // misaligned word, misaligned half, illegal size: ERR in cycle 1, no CYC
    issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0, 8'd1,
          1'b1, 4'b0000, 32'h0, 32'h0, 32'h0000007F, 1'b1, 0, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h23, 32'h0, 32'h0, 8'd1,
          1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 8'd1,
          1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1);

    // ACK outside BUS is ignored
    force_ack = 1'b1;
    tick(); tick();
    chk("spur_busy", {31'b0, busy}, 32'd0);
    chk("spur_done", {31'b0, done}, 32'd0);
    force_ack = 1'b0;

    // reset while in BUS drops the cycle without DONE
    exp_sel = 4'b1111; exp_oaddr = 32'h80; exp_we = 1'b0; sl_wait = 8'd255;
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h80; req = 1'b1;
    tick();
    req = 1'b0;
    chk("rb_cyc_on", {31'b0, cyc}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_cyc", {31'b0, cyc}, 32'd0);
    chk("rb_stb", {31'b0, stb}, 32'd0);
    chk("rb_sel", {28'b0, sel}, 32'd0);
    chk("rb_done", {31'b0, done}, 32'd0);
    chk("rb_busy", {31'b0, busy}, 32'd0);
    tick();
    issue(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 32'h0BADF00D, 8'd1,
          1'b0, 4'b1111, 32'h84, 32'h0, 32'h0BADF00D, 1'b1, 2, 3);

`ifdef LSU_TIMEOUT_EN
    // ACK on the limit cycle still completes
    issue(1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 32'h600DCAFE, 8'd15,
          1'b0, 4'b1111, 32'h90, 32'h0, 32'h600DCAFE, 1'b1, 16, 17);
    // no ACK: 16 BUS cycles then ERR
    issue(1'b0, 2'b10, 1'b0, 32'h94, 32'h0, 32'h0, 8'd255,
          1'b1, 4'b1111, 32'h94, 32'h0, 32'h600DCAFE, 1'b1, 16, 17);
`else
    // without the timeout a slow slave is simply waited for
    issue(1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 32'h600DCAFE, 8'd20,
          1'b0, 4'b1111, 32'h90, 32'h0, 32'h600DCAFE, 1'b1, 21, 22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
